// File: rtl/fb_pkg.sv
// Shared constants, FSM encoding and burst-address helper for the frame-buffer arbiter.
package fb_pkg;
  localparam int BURST_LEN    = 256;
  localparam int FRAME_BURSTS = 3600;
  localparam int BANK_SHIFT   = 20;
  localparam int FIFO_DEPTH   = 1024;
  localparam int RD_URGENT    = 256;
  localparam int ADDR_W       = 24;
  localparam int LVL_W        = 11;
  localparam int PTR_W        = 12;
  localparam int LEN_W        = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DONE
  } fb_state_e;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic bank, input logic [PTR_W-1:0] ptr);
    return (ADDR_W'(bank) << BANK_SHIFT) | (ADDR_W'(ptr) << $clog2(BURST_LEN));
  endfunction
endpackage

// File: rtl/fb_addr_gen.sv
// One burst pointer with its frame-start pending flag and end-of-frame detection.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame_start,
  input  logic             i_idle,
  input  logic             i_burst_done,
  output logic             o_restart,
  output logic [PTR_W-1:0] o_ptr,
  output logic             o_avail,
  output logic             o_frame_done
);
  logic [PTR_W-1:0] r_ptr;
  logic             r_pend;

  // The restart is visible to arbitration in the same idle cycle it is applied.
  assign o_restart    = i_idle & r_pend;
  assign o_ptr        = o_restart ? '0 : r_ptr;
  assign o_avail      = o_ptr < PTR_W'(FRAME_BURSTS);
  assign o_frame_done = i_burst_done & (r_ptr == PTR_W'(FRAME_BURSTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_pend <= 1'b0;
    end else begin
      // A pulse landing on the apply cycle re-arms the flag for the next idle window.
      r_pend <= i_frame_start | (r_pend & ~i_idle);
      if (o_restart)         r_ptr <= '0;
      else if (i_burst_done) r_ptr <= r_ptr + PTR_W'(1);
    end
  end
endmodule

// File: rtl/fb_rw_arbiter.sv
// Shares the SDRAM burst port between camera writes and display reads, with ping-pong banks.
module fb_rw_arbiter
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [LVL_W-1:0]  wr_fifo_level,
  input  logic [LVL_W-1:0]  rd_fifo_level,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  input  logic              mem_ack,
  input  logic              mem_done,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_valid
);
  fb_state_e         r_state, w_state_nxt;
  logic              r_gnt_wr, r_last_wr, r_wr_bank, r_rd_bank, r_done_bank, r_frame_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              w_idle, w_burst_done, w_wr_elig, w_rd_elig, w_grant, w_grant_rd;
  logic              w_wr_restart, w_rd_restart, w_wr_avail, w_rd_avail;
  logic              w_wr_frame_done, w_unused_rd_done;
  logic              w_wr_bank_eff, w_rd_bank_eff;
  logic [PTR_W-1:0]  w_wr_ptr, w_rd_ptr;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_burst_done = (r_state == ST_WAIT_DONE) & mem_done;

  fb_addr_gen u_wr_ag (
    .clk(clk), .rst_n(rst_n), .i_frame_start(wr_frame_start), .i_idle(w_idle),
    .i_burst_done(w_burst_done & r_gnt_wr), .o_restart(w_wr_restart), .o_ptr(w_wr_ptr),
    .o_avail(w_wr_avail), .o_frame_done(w_wr_frame_done)
  );

  fb_addr_gen u_rd_ag (
    .clk(clk), .rst_n(rst_n), .i_frame_start(rd_frame_start), .i_idle(w_idle),
    .i_burst_done(w_burst_done & ~r_gnt_wr), .o_restart(w_rd_restart), .o_ptr(w_rd_ptr),
    .o_avail(w_rd_avail), .o_frame_done(w_unused_rd_done)
  );

  // Writer moves to the bank opposite the last finished frame; reader follows the finished one.
  assign w_wr_bank_eff = (w_wr_restart & r_frame_valid) ? ~r_done_bank : r_wr_bank;
  assign w_rd_bank_eff = (w_rd_restart & r_frame_valid) ?  r_done_bank : r_rd_bank;

  assign w_wr_elig = init_done && (wr_fifo_level >= LVL_W'(BURST_LEN)) && w_wr_avail;
  assign w_rd_elig = init_done && (rd_fifo_level <= LVL_W'(FIFO_DEPTH - BURST_LEN)) && w_rd_avail;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = w_rd_elig | w_wr_elig;
    w_grant_rd  = w_rd_elig & ((rd_fifo_level < LVL_W'(RD_URGENT)) | ~w_wr_elig | r_last_wr);
    unique case (r_state)
      ST_IDLE:      if (w_grant)  w_state_nxt = ST_REQ;
      ST_REQ:       if (mem_ack)  w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (mem_done) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_wr      <= 1'b0;
      r_last_wr     <= 1'b0;
      r_addr        <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_done_bank   <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      if (w_idle) begin
        r_wr_bank <= w_wr_bank_eff;
        r_rd_bank <= w_rd_bank_eff;
        if (w_grant) begin
          r_gnt_wr <= ~w_grant_rd;
          r_addr   <= w_grant_rd ? burst_addr(w_rd_bank_eff, w_rd_ptr)
                                 : burst_addr(w_wr_bank_eff, w_wr_ptr);
        end
      end
      if (w_burst_done) r_last_wr <= r_gnt_wr;
      if (w_wr_frame_done) begin
        r_done_bank   <= r_wr_bank;
        r_frame_valid <= 1'b1;
      end
    end
  end

  assign mem_req     = (r_state == ST_REQ);
  assign mem_we      = r_gnt_wr;
  assign mem_addr    = r_addr;
  assign mem_len     = LEN_W'(BURST_LEN);
  assign wr_bank     = r_wr_bank;
  assign rd_bank     = r_rd_bank;
  assign frame_valid = r_frame_valid;
endmodule

// File: doc/fb_rw_arbiter.md
Name: fb_rw_arbiter

Overview:
- Shares the single SDRAM burst port between the camera write path and the 1280x720 RGB565 display read path.
- Issues fixed-length burst requests, generates the frame-buffer address for each burst and manages ping-pong frame banks.
- Sits between the camera/display FIFOs and the SDRAM controller; the display FIFO feeds the VGA timing driver's rgb_data.

Parameters:
- BURST_LEN, 256, words per burst.
- FRAME_BURSTS, 3600, bursts per frame (1280*720/256).
- BANK_SHIFT, 20, address bit that selects the frame bank.
- FIFO_DEPTH, 1024, depth of both the camera and display FIFOs, in words.
- RD_URGENT, 256, display FIFO level below which a read request overrides fairness.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  SDRAM initialisation complete
- wr_fifo_level  in  11  camera FIFO word count
- rd_fifo_level  in  11  display FIFO word count
- wr_frame_start  in  1  1-cycle pulse at camera frame start
- rd_frame_start  in  1  1-cycle pulse at display frame start (vsync)
- mem_req  out  1  burst request
- mem_we  out  1  1 = write burst, 0 = read burst
- mem_addr  out  24  burst start word address
- mem_len  out  9  burst length, constant BURST_LEN
- mem_ack  in  1  controller accepted the request
- mem_done  in  1  1-cycle pulse when the burst completes
- wr_bank  out  1  bank currently being written
- rd_bank  out  1  bank currently being read
- frame_valid  out  1  at least one complete frame has been written

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_len=BURST_LEN.
  - wr_bank=0, rd_bank=1, frame_valid=0.
  - Internal: wr_ptr=0, rd_ptr=0, done_bank=0, last_grant=read, pending flags=0, state=IDLE.
- Eligibility:
  - wr_elig = init_done && wr_fifo_level>=BURST_LEN && wr_ptr<FRAME_BURSTS.
  - rd_elig = init_done && (FIFO_DEPTH-rd_fifo_level)>=BURST_LEN && rd_ptr<FRAME_BURSTS.
- FSM states: IDLE, REQ, WAIT_DONE.
- IDLE:
  - First apply the pending frame-start flags.
  - Then grant one requester if any is eligible, and go to REQ on the next cycle.
  - Grant rule: read wins if rd_fifo_level<RD_URGENT; otherwise, if both are eligible, grant the requester opposite to last_grant; otherwise grant the single eligible requester.
- REQ:
  - mem_req=1; mem_we, mem_addr and mem_len are held stable until mem_ack is sampled high.
  - On mem_ack: mem_req drops the next cycle and the FSM goes to WAIT_DONE.
- WAIT_DONE:
  - On mem_done, increment the granted pointer, update last_grant and return to IDLE.
  - Minimum spacing between bursts is therefore one IDLE cycle.
- Address: mem_addr = (bank<<BANK_SHIFT) + ptr*BURST_LEN, i.e. {3'b0, bank, ptr[11:0], 8'b0}; bits above bank are 0.
- Latency: eligibility true in IDLE → mem_req high 1 cycle later.
- Write completion: the mem_done that brings wr_ptr to FRAME_BURSTS sets done_bank<=wr_bank and frame_valid<=1.
- wr_frame_start:
  - Sets wr_pend; the flag is applied in IDLE, never mid-burst.
  - When applied: wr_ptr<=0, and wr_bank<=~done_bank if frame_valid (wr_bank is unchanged otherwise).
  - An incomplete frame is dropped: the pointer restarts and the bank does not advance.
- rd_frame_start:
  - Sets rd_pend; applied in IDLE.
  - When applied: rd_ptr<=0, and rd_bank<=done_bank if frame_valid; otherwise rd_bank keeps its reset value and the display shows don't-care data.
- Simultaneous events:
  - Both pend flags are applied in the same IDLE cycle, before arbitration.
  - A frame-start pulse arriving in the same cycle its flag is applied re-sets the flag.
  - A second pulse on an already-set flag is absorbed.
- Reading ends after FRAME_BURSTS read bursts, until the next rd_frame_start.
- Tearing when the writer laps the reader is accepted with two banks.
- init_done low: no new grant is made; a burst already in REQ or WAIT_DONE completes normally.
- Reset asserted mid-burst: all state clears immediately and mem_req drops; the SDRAM controller shares rst_n.

Decomposition:
- Shared package fb_pkg:
  - FSM state encoding.
  - BURST_LEN, FRAME_BURSTS, BANK_SHIFT.
  - Address-width constant (24) and FIFO level width (11).
- One natural sub-module: fb_addr_gen. It holds one pointer, frame-done detection and pend-flag logic, and is instantiated twice (write, read). The arbiter FSM stays in the top module.

Test Plan:
- Reset, init_done=1, wr_fifo_level=256, rd_fifo_level=1000 → one write burst: mem_we=1, mem_addr=0x000000, mem_len=256; after ack+done the next write uses addr 0x000100.
- Both eligible, rd_fifo_level=600 → grants alternate W,R,W,R; the first read addr is 0x100000 (rd_bank=1 from reset).
- Both eligible, rd_fifo_level=100 → read granted on consecutive bursts regardless of last_grant.
- mem_ack held low for 20 cycles → mem_req, mem_addr and mem_we stay constant throughout; no second request is issued.
- Write 3600 bursts → frame_valid=1, done_bank=0. wr_frame_start → wr_bank=1, next write addr 0x100000. rd_frame_start → rd_bank=0, read addr 0x000000.
- wr_frame_start pulsed during WAIT_DONE at wr_ptr=10 → the current burst completes at the old address; the next write uses wr_ptr=0 and the same bank (frame dropped, frame_valid unchanged).
